// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: GPR geometry and the debug
// register-access FSM state encoding.
package cpu_pkg;

  localparam int NUM_GPR = 32;
  localparam int GPR_AW  = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_CAPTURE,
    S_WRITE,
    S_RESP
  } dbg_state_t;

endpackage

// File: rtl/regfile_dbg_port.sv
// Debug-side GPR access port: abstract read/write commands from the
// debug module, burst reads, one response per register.
module regfile_dbg_port
  import cpu_pkg::*;
#(
  parameter int XW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halted_ip,
  input  logic              cmd_valid_ip,
  output logic              cmd_ready_op,
  input  logic              cmd_write_ip,
  input  logic [GPR_AW-1:0] cmd_addr_ip,
  input  logic [GPR_AW-1:0] cmd_count_ip,
  input  logic [XW-1:0]     cmd_wdata_ip,
  output logic              rsp_valid_op,
  input  logic              rsp_ready_ip,
  output logic [XW-1:0]     rsp_rdata_op,
  output logic              rsp_err_op,
  output logic              rsp_last_op,
  output logic              dbg_active_op,
  output logic [GPR_AW-1:0] rf_rd_addr_op,
  input  logic [XW-1:0]     rf_rd_data_ip,
  output logic [GPR_AW-1:0] rf_wr_addr_op,
  output logic [XW-1:0]     rf_wr_data_op,
  output logic              rf_wr_en_op
);

  dbg_state_t        r_state;
  dbg_state_t        w_state_nxt;
  logic [GPR_AW-1:0] r_addr;
  logic [GPR_AW-1:0] r_rem;
  logic [XW-1:0]     r_wdata;
  logic [XW-1:0]     r_rdata;
  logic              r_err;

  logic              w_accept;
  logic [GPR_AW:0]   w_end;
  logic              w_cmd_err;
  logic              w_last;
  logic              w_rsp_hs;
  logic              w_in_rd;

  assign w_accept  = cmd_valid_ip && (r_state == S_IDLE);
  // Carry out of the 6-bit sum means the burst runs past x31.
  assign w_end     = {1'b0, cmd_addr_ip} + {1'b0, cmd_count_ip};
  assign w_cmd_err = !halted_ip
                   || (cmd_write_ip && (cmd_count_ip != '0))
                   || w_end[GPR_AW];
  assign w_last    = r_err || (r_rem == '0);
  assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready_ip;
  assign w_in_rd   = (r_state == S_RD_ISSUE)
                   || (r_state == S_RD_CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_cmd_err)         w_state_nxt = S_RESP;
          else if (cmd_write_ip) w_state_nxt = S_WRITE;
          else                   w_state_nxt = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE:   w_state_nxt = S_RD_CAPTURE;
      S_RD_CAPTURE: w_state_nxt = S_RESP;
      S_WRITE:      w_state_nxt = S_RESP;
      S_RESP: begin
        if (w_rsp_hs) begin
          if (w_last)         w_state_nxt = S_IDLE;
          else if (halted_ip) w_state_nxt = S_RD_ISSUE;
          else                w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_rem   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= cmd_addr_ip;
      r_rem   <= w_cmd_err ? '0 : cmd_count_ip;
      r_wdata <= cmd_write_ip ? cmd_wdata_ip : '0;
      r_rdata <= '0;
      r_err   <= w_cmd_err;
    end else if (r_state == S_RD_CAPTURE) begin
      r_rdata <= rf_rd_data_ip;
    end else if (w_rsp_hs && !w_last) begin
      r_rdata <= '0;
      // Halt lost: replace the next beat with a terminal error.
      if (!halted_ip) begin
        r_err <= 1'b1;
      end else begin
        r_addr <= r_addr + 1'b1;
        r_rem  <= r_rem - 1'b1;
      end
    end
  end

  always_comb begin
    cmd_ready_op  = (r_state == S_IDLE);
    dbg_active_op = (r_state != S_IDLE);
    rsp_valid_op  = (r_state == S_RESP);
    rsp_rdata_op  = rsp_valid_op ? r_rdata : '0;
    rsp_err_op    = rsp_valid_op && r_err;
    rsp_last_op   = rsp_valid_op && w_last;
    rf_rd_addr_op = w_in_rd ? r_addr : '0;
    rf_wr_en_op   = (r_state == S_WRITE) && (r_addr != '0);
    rf_wr_addr_op = (r_state == S_WRITE) ? r_addr : '0;
    rf_wr_data_op = (r_state == S_WRITE) ? r_wdata : '0;
  end

endmodule
